// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector with runtime-loadable pattern, overlap/non-overlap modes and a match counter.
// Define SEQ_DETECT_CNT_SAT_EN to make the counter saturate and drive count_sat; otherwise the counter wraps.
module seq_detect_param #(
  parameter int unsigned      PAT_W       = 3,
  parameter int unsigned      CNT_W       = 10,
  parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(3'b010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x,
  input  logic             mode_ovl,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             count_sat,
  output logic [PAT_W-1:0] pat_q
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_ARMED
  } state_e;

  state_e             state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_nx;
  logic [PAT_W-1:0]   hist_q, hist_d, hist_sh;
  logic [PAT_W-1:0]   pat_d;
  logic               y_q, y_d;
  logic               match;
  logic [CNT_W-1:0]   count_q, count_d;

  // Detector: pattern load beats sampling; a non-overlap match restarts collection from scratch.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    state_d = state_q;
    fill_d  = fill_q;
    hist_d  = hist_q;
    pat_d   = pat_q;
    y_d     = 1'b0;
    match   = 1'b0;
    hist_sh = {hist_q[PAT_W-2:0], x};
    fill_nx = (state_q == S_ARMED) ? FILL_FULL : fill_q + FILL_W'(1);

    if (pat_load) begin
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else if (en) begin
      match = (fill_nx == FILL_FULL) && (hist_sh == pat_q);
      y_d   = match;
      if (match && !mode_ovl) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = hist_sh;
        fill_d = fill_nx;
      end
    end

    if (fill_d == '0) begin
      state_d = S_IDLE;
    end else if (fill_d == FILL_FULL) begin
      state_d = S_ARMED;
    end else begin
      state_d = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      hist_q  <= '0;
      pat_q   <= DEFAULT_PAT;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      y_q     <= y_d;
    end
  end

`ifdef SEQ_DETECT_CNT_SAT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic count_sat_q, count_sat_d;

  // Clear wins over a same-cycle match; the saturation flag is sticky until clear or reset.
  always_comb begin
    count_d     = count_q;
    count_sat_d = count_sat_q;
    if (clr_cnt) begin
      count_d     = '0;
      count_sat_d = 1'b0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d     = count_q + CNT_W'(1);
      count_sat_d = (count_d == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q     <= '0;
      count_sat_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      count_sat_q <= count_sat_d;
    end
  end

  assign count_sat = count_sat_q;
`else
  always_comb begin
    count_d = count_q;
    if (clr_cnt) begin
      count_d = '0;
    end else if (match) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_sat = 1'b0;
`endif

  assign y     = y_q;
  assign count = count_q;

endmodule

// File: doc/seq_detect_param.md
# seq_detect_param

Parametrised serial bit-pattern detector with a match counter, the successor to our fixed "010" detector FSM. It samples one serial bit `x` per enabled clock and compares the last `PAT_W` bits against a runtime-loadable pattern. It supports overlapping and non-overlapping match modes and raises a one-cycle `y` pulse per match. It sits on the serial receive path and feeds match statistics to status logic.

## Interface
- `PAT_W`, 3: pattern length in bits, legal range 2..16.
- `CNT_W`, 10: match counter width, legal range 2..32.
- `DEFAULT_PAT`, 3'b010: pattern loaded at reset; `PAT_W` bits wide.

- `clk`  in  1  single clock; all logic is on posedge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  sample enable; `x` is consumed only when high.
- `x`  in  1  serial data bit.
- `mode_ovl`  in  1  1 = overlapping matches, 0 = non-overlapping.
- `pat_load`  in  1  load `pat_in` as the new pattern.
- `pat_in`  in  PAT_W  new pattern; MSB is the first bit received.
- `clr_cnt`  in  1  synchronous clear of `count`.
- `y`  out  1  registered match pulse.
- `count`  out  CNT_W  number of matches.
- `count_sat`  out  1  counter saturated (see Configuration).
- `pat_q`  out  PAT_W  currently active pattern.

## Operation
- **Internal state:**
  - history shift register `hist[PAT_W-1:0]`;
  - fill counter `fill` (0..PAT_W);
  - pattern register.
- **FSM states:**
  - IDLE: `fill`=0.
  - FILL: 0<`fill`<PAT_W.
  - ARMED: `fill`=PAT_W.
- **Priority per edge:** `rst`==0 > `pat_load` > `en`. `clr_cnt` is evaluated independently of `en`.
- **Reset:** pattern=`DEFAULT_PAT`, `hist`=0, state IDLE, `y`=0, `count`=0, `count_sat`=0.
- **`pat_load`=1:**
  - pattern <= `pat_in`; `hist` <= 0; state -> IDLE; `y` <= 0.
  - `x` is ignored that cycle even if `en`=1.
  - `count` is unaffected.
- **`en`=1, no load:**
  - `hist` <= {`hist`[PAT_W-2:0], `x`}.
  - `fill` increments, saturating at PAT_W. Transitions: IDLE->FILL, FILL->FILL/ARMED, ARMED->ARMED.
- **Match condition:** the post-shift `fill`==PAT_W and the post-shift `hist`==pattern.
- **On match:**
  - `y` <= 1 for exactly one cycle; `count` increments.
  - Overlap mode: stay ARMED, so history bits are reused.
  - Non-overlap mode: `fill` <= 0 and `hist` <= 0 (state -> IDLE), so the next match needs PAT_W fresh bits.
- **`en`=0:** `hist`, `fill` and state hold; `y` <= 0.
- **`mode_ovl` changes:** take effect on the next match; there is no flush.
- **`clr_cnt`=1:**
  - `count` <= 0 and `count_sat` <= 0.
  - If a match occurs the same cycle, the clear wins: `count`=0, but `y` still pulses.

## Timing
- **Latency:** the edge that samples the final pattern bit also sets `y` and updates `count`. Both are visible one cycle after that bit is presented.
- **`y`:** always a single-cycle pulse. Back-to-back pulses are possible:
  - in overlap mode when the pattern is periodic (e.g. all-ones);
  - never closer than PAT_W enabled cycles apart in non-overlap mode.
- **Reset:** a reset asserted mid-stream discards partial history. The first match after release requires PAT_W new bits.
- **`pat_q`:** updates on the edge after `pat_load`.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- **`SEQ_DETECT_CNT_SAT_EN` defined:**
  - `count` saturates at 2^CNT_W-1 and further matches do not change it.
  - `count_sat` goes to 1 on the edge `count` reaches max and stays until `clr_cnt` or reset.
- **Not defined:**
  - `count` wraps modulo 2^CNT_W.
  - `count_sat` is tied to 0.
- `y` behaviour is identical in both builds.

## Test plan
- **Overlap, default pattern:** reset, `mode_ovl`=1, `en`=1, x = 0,1,0,1,0 -> `y` pulses after the 3rd and 5th bits; `count`=2.
- **Non-overlap, same stream:** `mode_ovl`=0, x = 0,1,0,1,0 -> `y` pulses only after the 3rd bit; `count`=1.
- **Pattern load:** `pat_load`=1 with `pat_in`=3'b110 while `x`=1 -> `pat_q`=110 and no shift occurs. Then x = 1,1,0 -> one `y` pulse. The stream 0,1,0 afterwards gives no pulse.
- **Enable gaps and reset mid-stream:**
  - x = 0,1, then `en`=0 for 4 cycles, then x = 0 -> match; `y` pulses once.
  - x = 0,1, then `rst`=0 for one cycle, then x = 0 -> no match.
- **Counter limits:** CNT_W=2, 5 matches.
  - With `SEQ_DETECT_CNT_SAT_EN`: `count`=3 and `count_sat`=1.
  - Without it: `count`=1 and `count_sat`=0.
- **Clear collision:** `clr_cnt`=1 on the cycle of a match edge -> `count`=0 and `y`=1 for one cycle.
